// File: rtl/fetch_byte_assembler.sv
// Instruction fetch front end: byte-serial MMU reads packed into words, buffered with their PC.
// Define FETCH_BIG_ENDIAN_EN to place the byte at fetchPc in the most significant lane.
module fetch_byte_assembler #(
    parameter int                         ADDRESS_WIDTH = 32,
    parameter int                         BUS_WIDTH     = 8,
    parameter int                         WORD_BYTES    = 4,
    parameter int                         FIFO_DEPTH    = 4,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            redirect,
    input  logic [ADDRESS_WIDTH-1:0]        redirectPc,
    output logic [ADDRESS_WIDTH-1:0]        memAddr,
    output logic                            memRequest,
    input  logic                            memBusy,
    input  logic [BUS_WIDTH-1:0]            memData,
    output logic [WORD_BYTES*BUS_WIDTH-1:0] instr,
    output logic [ADDRESS_WIDTH-1:0]        instrPc,
    output logic                            instrValid,
    input  logic                            instrReady
);
    localparam int IDX_W = $clog2(WORD_BYTES);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(FIFO_DEPTH);

    typedef logic [WORD_BYTES-1:0][BUS_WIDTH-1:0] word_t;
    typedef enum logic [2:0] {S_REQ, S_WAIT, S_GAP, S_HOLD, S_DRAIN} state_e;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [IDX_W-1:0]         byte_idx_q, byte_idx_d;
    word_t                    word_q, word_d;
    logic                     gap_skip_q, gap_skip_d;
    logic                     mem_request_q, mem_request_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    word_t                    fifo_word_q [FIFO_DEPTH];
    word_t                    fifo_word_d [FIFO_DEPTH];
    logic [ADDRESS_WIDTH-1:0] fifo_pc_q [FIFO_DEPTH];
    logic [ADDRESS_WIDTH-1:0] fifo_pc_d [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     push, pop;
    logic [IDX_W-1:0]         lane;

`ifdef FETCH_BIG_ENDIAN_EN
    assign lane = LAST_IDX - byte_idx_q;
`else
    assign lane = byte_idx_q;
`endif

    assign instrValid = (count_q != '0);
    assign pop        = instrValid && instrReady;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        gap_skip_d  = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        fifo_word_d = fifo_word_q;
        fifo_pc_d   = fifo_pc_q;
        push        = 1'b0;

        case (state_q)
            S_REQ:   if (memBusy) state_d = S_WAIT;
            S_WAIT:  if (!memBusy) begin
                word_d[lane] = memData;
                state_d      = S_GAP;
            end
            S_GAP: begin
                state_d = S_REQ;
                // A GAP reached from DRAIN only burns the cycle; the byte was already dropped.
                if (!gap_skip_q) begin
                    if (byte_idx_q == LAST_IDX) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + ADDRESS_WIDTH'(WORD_BYTES);
                        byte_idx_d = '0;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
            end
            S_HOLD:  if (count_q != FULL) state_d = S_REQ;
            S_DRAIN: if (!memBusy) begin
                state_d    = S_GAP;
                gap_skip_d = 1'b1;
            end
            default: state_d = S_REQ;
        endcase

        if (redirect) begin
            push       = 1'b0;
            fetch_pc_d = redirectPc;
            byte_idx_d = '0;
            word_d     = '0;
            case (state_q)
                S_REQ:          state_d = memBusy ? S_DRAIN : S_REQ;
                S_WAIT:         state_d = S_DRAIN;
                S_GAP, S_HOLD:  state_d = S_REQ;
                default:        ;
            endcase
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                fifo_word_d[wr_ptr_q] = word_q;
                fifo_pc_d[wr_ptr_q]   = fetch_pc_q;
                wr_ptr_d              = wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (!push && pop) count_d = count_q - 1'b1;
        end

        // Starting a fresh word needs a free slot; a partial word already owns one.
        if (state_q == S_GAP && state_d == S_REQ && byte_idx_d == '0 && count_d == FULL)
            state_d = S_HOLD;

        mem_request_d = (state_d == S_REQ) || (state_d == S_WAIT) || (state_d == S_DRAIN);
        mem_addr_d    = (state_d == S_REQ) ? fetch_pc_d + ADDRESS_WIDTH'(byte_idx_d) : mem_addr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_REQ;
            fetch_pc_q    <= RESET_PC;
            byte_idx_q    <= '0;
            word_q        <= '0;
            gap_skip_q    <= 1'b0;
            mem_request_q <= 1'b0;
            mem_addr_q    <= RESET_PC;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_word_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
            end
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            byte_idx_q    <= byte_idx_d;
            word_q        <= word_d;
            gap_skip_q    <= gap_skip_d;
            mem_request_q <= mem_request_d;
            mem_addr_q    <= mem_addr_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            fifo_word_q   <= fifo_word_d;
            fifo_pc_q     <= fifo_pc_d;
        end
    end

    assign memRequest = mem_request_q;
    assign memAddr    = mem_addr_q;
    assign instr      = fifo_word_q[rd_ptr_q];
    assign instrPc    = fifo_pc_q[rd_ptr_q];
endmodule

// File: tb/tb_fetch_byte_assembler.sv
// Scoreboard bench for fetch_byte_assembler with a one-cycle-busy MMU model.
module tb_fetch_byte_assembler;
    logic        clk = 1'b0;
    logic        reset, redirect, memRequest, memBusy, instrValid, instrReady;
    logic [31:0] redirectPc, memAddr, instr, instrPc;
    logic [7:0]  memData;
    logic        served_q;

    typedef struct packed { logic [31:0] pc; logic [31:0] w; } exp_t;
    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fetch_byte_assembler dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirectPc(redirectPc),
        .memAddr(memAddr), .memRequest(memRequest), .memBusy(memBusy), .memData(memData),
        .instr(instr), .instrPc(instrPc), .instrValid(instrValid), .instrReady(instrReady)
    );

    // Memory contents: 0x11,0x22,0x33,0x44 at 0..3, else low address byte ^ 0x5A.
    function automatic logic [7:0] byte_at(input logic [31:0] a);
        if (a < 32'd4) return 8'h11 * (a[7:0] + 8'd1);
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] pc);
`ifdef FETCH_BIG_ENDIAN_EN
        return {byte_at(pc), byte_at(pc + 32'd1), byte_at(pc + 32'd2), byte_at(pc + 32'd3)};
`else
        return {byte_at(pc + 32'd3), byte_at(pc + 32'd2), byte_at(pc + 32'd1), byte_at(pc)};
`endif
    endfunction

    // MMU: busy for the first cycle of each request, data valid once busy drops.
    assign memBusy = memRequest & ~served_q;
    always @(posedge clk) begin
        if (reset) begin
            served_q <= 1'b0;
            memData  <= 8'h00;
        end else if (memBusy) begin
            served_q <= 1'b1;
            memData  <= byte_at(memAddr);
        end else if (!memRequest) begin
            served_q <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every accepted word is popped from the scoreboard and compared.
    always begin
        @(negedge clk);
        #2;
        if (instrValid && instrReady) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_word: got pc %0h word %0h expected none", instrPc, instr);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("word_pc", instrPc, e.pc);
                chk("word_data", instr, e.w);
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1; instrReady = 1'b0; redirect = 1'b0; redirectPc = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_memRequest", memRequest, 0);
            chk("rst_memAddr", memAddr, 0);
            chk("rst_instr", instr, 0);
            chk("rst_instrPc", instrPc, 0);
            chk("rst_instrValid", instrValid, 0);
        end
        reset = 1'b0;
    endtask

    task automatic wait_req(input string nm, input logic [31:0] addr);
        for (int i = 0; i < 20 && !memRequest; i++) begin @(posedge clk); #1; end
        chk({nm, "_req"}, memRequest, 1);
        chk({nm, "_addr"}, memAddr, addr);
    endtask

    task automatic drain(input int max);
        for (int i = 0; i < max && q.size() > 0; i++) begin
            instrReady = 1'b1;
            @(posedge clk); #1;
        end
        instrReady = 1'b0;
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_a [4];
        logic        prev, found;
        int          n;

        // Reset values, first request, first-word latency and byte order.
        do_reset();
`ifdef FETCH_BIG_ENDIAN_EN
        q.push_back('{pc: 32'h0, w: 32'h11223344});
`else
        q.push_back('{pc: 32'h0, w: 32'h44332211});
`endif
        instrReady = 1'b1;
        @(posedge clk); #1;
        chk("first_req", memRequest, 1);
        chk("first_addr", memAddr, 0);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k == 11) chk("valid_before_12", instrValid, 0);
            if (k == 12) chk("valid_at_12", instrValid, 1);
        end
        @(posedge clk); #1;
        instrReady = 1'b0;
        chk("first_word_popped", q.size(), 0);

        // Backpressure: four words fill the FIFO, then fetch stalls.
        do_reset();
        for (int i = 0; i < 6; i++) q.push_back('{pc: 32'(i * 4), w: word_at(32'(i * 4))});
        repeat (60) begin @(posedge clk); #1; end
        chk("full_stall_req", memRequest, 0);
        chk("full_valid", instrValid, 1);
        instrReady = 1'b1;
        @(posedge clk); #1;
        instrReady = 1'b0;
        wait_req("fetch16", 32'd16);

        // Pop in the same cycle word 16 is pushed: count unchanged, so word 20 starts.
        prev = 1'b0; found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (prev && !memRequest && memAddr == 32'd19) found = 1'b1;
            else prev = memRequest;
        end
        chk("gap16_seen", found, 1);
        instrReady = 1'b1;
        @(posedge clk); #1;
        instrReady = 1'b0;
        wait_req("fetch20", 32'd20);
        repeat (30) begin @(posedge clk); #1; end
        chk("refull_stall_req", memRequest, 0);
        drain(40);

        // Redirect while waiting on the byte at 0x6.
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (memRequest && !memBusy && memAddr == 32'h6) found = 1'b1;
        end
        chk("wait6_seen", found, 1);
        chk("pre_flush_valid", instrValid, 1);
        redirect = 1'b1; redirectPc = 32'h100;
        @(posedge clk); #1;
        redirect = 1'b0;
        chk("flush_valid", instrValid, 0);
        q.push_back('{pc: 32'h100, w: word_at(32'h100)});
        q.push_back('{pc: 32'h104, w: word_at(32'h104)});
        for (int i = 0; i < 10 && !(memRequest && memAddr != 32'h6); i++) begin @(posedge clk); #1; end
        chk("redir_addr", memAddr, 32'h100);
        drain(60);

        // Redirect from REQ with busy high, to an address that wraps.
        do_reset();
        @(posedge clk); #1;
        redirect = 1'b1; redirectPc = 32'hFFFF_FFFE;
        @(posedge clk); #1;
        redirect = 1'b0;
`ifdef FETCH_BIG_ENDIAN_EN
        q.push_back('{pc: 32'hFFFF_FFFE, w: 32'hA4A51122});
        q.push_back('{pc: 32'h2, w: 32'h33445E5F});
`else
        q.push_back('{pc: 32'hFFFF_FFFE, w: 32'h2211A5A4});
        q.push_back('{pc: 32'h2, w: 32'h5F5E4433});
`endif
        exp_a = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            if (memRequest && memBusy) begin
                chk($sformatf("wrap_addr%0d", n), memAddr, exp_a[n]);
                n++;
            end
            @(posedge clk); #1;
        end
        chk("wrap_addr_count", n, 4);
        drain(60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
